ctrl_pipe: RTL and testbench

- Receiving end of the main controller's decoded control bundle.
- Carries the ID-stage control signals through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 32-bit MIPS datapath.
- Also contains load-use hazard detection, branch flush and operand forwarding select.
- Sits between the controller/register-file read stage and the EX/MEM/WB datapath muxes.

---
 rtl/ctrl_pipe.sv | 189 ++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Purpose  : ID/EX, EX/MEM, MEM/WB control pipeline with load-use stall,
//            branch flush and operand-forwarding select. Optional macro
//            CTRL_PIPE_FWD_EN enables forwarding (otherwise RAW hazards stall).
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
  parameter int REGADDR_W = 5,
  parameter int ALUOP_W   = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_alusrc,
  input  logic                 id_memread,
  input  logic                 id_memwrite,
  input  logic                 id_memtoreg,
  input  logic                 id_regwrite,
  input  logic                 id_regdst,
  input  logic                 id_branch,
  input  logic [ALUOP_W-1:0]   id_aluop,
  input  logic [REGADDR_W-1:0] id_rs,
  input  logic [REGADDR_W-1:0] id_rt,
  input  logic [REGADDR_W-1:0] id_rd,
  input  logic                 ex_zero,
  output logic                 ex_alusrc,
  output logic                 ex_regdst,
  output logic [ALUOP_W-1:0]   ex_aluop,
  output logic [REGADDR_W-1:0] ex_rs,
  output logic [REGADDR_W-1:0] ex_rt,
  output logic                 mem_memread,
  output logic                 mem_memwrite,
  output logic                 pcsrc,
  output logic                 wb_memtoreg,
  output logic                 wb_regwrite,
  output logic [REGADDR_W-1:0] wb_dest,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic [1:0]           forward_a,
  output logic [1:0]           forward_b,
  output logic [CNT_W-1:0]     stall_count
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                 r_ex_memread, r_ex_memwrite, r_ex_memtoreg;
  logic                 r_ex_regwrite, r_ex_branch;
  logic [REGADDR_W-1:0] r_ex_dest;
  logic                 r_mem_memtoreg, r_mem_regwrite, r_mem_branch, r_mem_zero;
  logic [REGADDR_W-1:0] r_mem_dest;

  logic w_load_use, w_hazard, w_stall, w_flush, w_bubble;

  assign w_flush    = r_mem_branch & r_mem_zero;
  assign pcsrc      = w_flush;
  assign ifid_flush = w_flush;

  assign w_load_use = r_ex_memread & (r_ex_dest != '0) &
                      ((r_ex_dest == id_rs) | (r_ex_dest == id_rt));

`ifdef CTRL_PIPE_FWD_EN
  assign w_hazard = w_load_use;

  // EX/MEM result is newer than MEM/WB, so it is checked first
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (r_mem_regwrite && (r_mem_dest != '0) && (r_mem_dest == ex_rs))
      forward_a = 2'b10;
    else if (wb_regwrite && (wb_dest != '0) && (wb_dest == ex_rs))
      forward_a = 2'b01;
    if (r_mem_regwrite && (r_mem_dest != '0) && (r_mem_dest == ex_rt))
      forward_b = 2'b10;
    else if (wb_regwrite && (wb_dest != '0) && (wb_dest == ex_rt))
      forward_b = 2'b01;
  end
`else
  logic w_raw_ex, w_raw_mem;

  // Without forwarding, any pending write to a source register must drain
  assign w_raw_ex  = r_ex_regwrite & (r_ex_dest != '0) &
                     ((r_ex_dest == id_rs) | (r_ex_dest == id_rt));
  assign w_raw_mem = r_mem_regwrite & (r_mem_dest != '0) &
                     ((r_mem_dest == id_rs) | (r_mem_dest == id_rt));
  assign w_hazard  = w_load_use | w_raw_ex | w_raw_mem;
  assign forward_a = 2'b00;
  assign forward_b = 2'b00;
`endif

  // A taken branch discards the stalled instruction, so the stall is moot
  assign w_stall    = w_hazard & ~w_flush;
  assign w_bubble   = w_stall | w_flush;
  assign pc_write   = ~w_stall;
  assign ifid_write = ~w_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_alusrc     <= 1'b0;
      ex_regdst     <= 1'b0;
      ex_aluop      <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_memtoreg <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_branch   <= 1'b0;
      r_ex_dest     <= '0;
    end else if (w_bubble) begin
      ex_alusrc     <= 1'b0;
      ex_regdst     <= 1'b0;
      ex_aluop      <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_memtoreg <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_branch   <= 1'b0;
      r_ex_dest     <= '0;
    end else begin
      ex_alusrc     <= id_alusrc;
      ex_regdst     <= id_regdst;
      ex_aluop      <= id_aluop;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      r_ex_memread  <= id_memread;
      r_ex_memwrite <= id_memwrite;
      r_ex_memtoreg <= id_memtoreg;
      r_ex_regwrite <= id_regwrite & ~id_branch;
      r_ex_branch   <= id_branch;
      r_ex_dest     <= id_regdst ? id_rd : id_rt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_branch   <= 1'b0;
      r_mem_dest     <= '0;
      r_mem_zero     <= 1'b0;
    end else begin
      r_mem_zero <= ex_zero;
      if (w_flush) begin
        mem_memread    <= 1'b0;
        mem_memwrite   <= 1'b0;
        r_mem_memtoreg <= 1'b0;
        r_mem_regwrite <= 1'b0;
        r_mem_branch   <= 1'b0;
        r_mem_dest     <= '0;
      end else begin
        mem_memread    <= r_ex_memread;
        mem_memwrite   <= r_ex_memwrite;
        r_mem_memtoreg <= r_ex_memtoreg;
        r_mem_regwrite <= r_ex_regwrite;
        r_mem_branch   <= r_ex_branch;
        r_mem_dest     <= r_ex_dest;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_memtoreg <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_dest     <= '0;
    end else begin
      wb_memtoreg <= r_mem_memtoreg;
      wb_regwrite <= r_mem_regwrite;
      wb_dest     <= r_mem_dest;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_count <= '0;
    else if (w_stall && !(&stall_count))
      stall_count <= stall_count + c_cnt_one;
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Purpose  : Directed scenarios plus randomized run against an
//            instruction-level pipeline model of ctrl_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] MAXC = '1;
`ifdef CTRL_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int K_NOP = 0, K_LW = 1, K_SW = 2, K_R = 3, K_BEQ = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic id_alusrc, id_memread, id_memwrite, id_memtoreg, id_regwrite, id_regdst, id_branch;
  logic [1:0] id_aluop;
  logic [4:0] id_rs, id_rt, id_rd;
  logic ex_zero;
  logic ex_alusrc, ex_regdst, mem_memread, mem_memwrite, pcsrc;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rs, ex_rt, wb_dest;
  logic wb_memtoreg, wb_regwrite, pc_write, ifid_write, ifid_flush;
  logic [1:0] forward_a, forward_b;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int failures = 0;

  ctrl_pipe #(.REGADDR_W(5), .ALUOP_W(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_alusrc(id_alusrc), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite), .id_regdst(id_regdst),
    .id_branch(id_branch), .id_aluop(id_aluop),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_aluop(ex_aluop),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .pcsrc(pcsrc),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_dest(wb_dest),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .forward_a(forward_a), .forward_b(forward_b), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       alusrc, regdst;
    logic [1:0] aluop;
    logic [4:0] rs, rt;
    logic       memread, memwrite, memtoreg, regwrite, branch;
    logic [4:0] dest;
    logic       zero;
  } stage_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic drive(input int kind, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_alusrc = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    id_regwrite = 0; id_regdst = 0; id_branch = 0; id_aluop = 2'b00;
    id_rs = rs; id_rt = rt; id_rd = rd;
    case (kind)
      K_LW:  begin id_alusrc = 1; id_memread = 1; id_memtoreg = 1; id_regwrite = 1; end
      K_SW:  begin id_alusrc = 1; id_memwrite = 1; end
      K_R:   begin id_regwrite = 1; id_regdst = 1; id_aluop = 2'b10; end
      // regwrite set on purpose: the pipe must suppress it for branches
      K_BEQ: begin id_branch = 1; id_regwrite = 1; id_aluop = 2'b01; end
      default: ;
    endcase
  endtask

  task automatic do_reset;
    reset = 1'b0;
    ex_zero = 1'b0;
    drive(K_NOP, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    ex_zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {id_alusrc, id_memread, id_memwrite, id_memtoreg, id_regwrite, id_regdst, id_branch} = 7'($urandom);
      id_aluop = 2'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
      ex_zero = 1'($urandom);
      tick;
    end
    settle;
    checks++;
    if ({ex_alusrc, ex_regdst, ex_aluop, ex_rs, ex_rt, mem_memread, mem_memwrite,
         wb_memtoreg, wb_regwrite, wb_dest} !== 25'd0) begin
      failures++;
      $display("FAIL reset_pipe_regs actual=%h expected=0", {ex_alusrc, ex_regdst, ex_aluop, ex_rs,
               ex_rt, mem_memread, mem_memwrite, wb_memtoreg, wb_regwrite, wb_dest});
    end
    checks++;
    if ({pc_write, ifid_write, pcsrc, ifid_flush, forward_a, forward_b} !== 8'b1100_0000) begin
      failures++;
      $display("FAIL reset_hazard_outs actual=%b expected=11000000",
               {pc_write, ifid_write, pcsrc, ifid_flush, forward_a, forward_b});
    end
    checks++;
    if (stall_count !== '0) begin
      failures++;
      $display("FAIL reset_stall_count actual=%0d expected=0", stall_count);
    end
    reset = 1'b1;
    ex_zero = 1'b0;
    drive(K_LW, 5'd1, 5'd9, 5'd0);
    tick;
    drive(K_NOP, 0, 0, 0);
    settle;
    checks++;
    if ({ex_alusrc, ex_aluop, ex_regdst} !== 4'b1000) begin
      failures++;
      $display("FAIL lw_ex_stage actual=%b expected=1000", {ex_alusrc, ex_aluop, ex_regdst});
    end
    tick;
    settle;
    checks++;
    if ({mem_memread, wb_memtoreg} !== 2'b10) begin
      failures++;
      $display("FAIL lw_mem_stage actual=%b expected=10", {mem_memread, wb_memtoreg});
    end
    tick;
    settle;
    checks++;
    if ({wb_memtoreg, wb_regwrite, wb_dest} !== {2'b11, 5'd9}) begin
      failures++;
      $display("FAIL lw_wb_stage actual=%b expected=%b", {wb_memtoreg, wb_regwrite, wb_dest}, {2'b11, 5'd9});
    end
  endtask

  task automatic test_load_use;
    int nps = 0, nis = 0;
    bit seen = 0;
    int exp_st = FWD ? 1 : 2;
    logic [1:0] exp_fa = FWD ? 2'b01 : 2'b00;
    do_reset;
    drive(K_LW, 5'd1, 5'd8, 5'd0);
    tick;
    drive(K_R, 5'd8, 5'd2, 5'd5);
    for (int c = 0; c < 6; c++) begin
      settle;
      if (!pc_write) nps++;
      if (!ifid_write) nis++;
      if (c == 1) begin
        checks++;
        if ({ex_alusrc, ex_regdst, ex_aluop} !== 4'b0000) begin
          failures++;
          $display("FAIL loaduse_bubble actual=%b expected=0000", {ex_alusrc, ex_regdst, ex_aluop});
        end
      end
      if (!seen && ex_regdst && ex_rs == 5'd8) begin
        seen = 1;
        checks++;
        if (forward_a !== exp_fa) begin
          failures++;
          $display("FAIL loaduse_forward_a actual=%b expected=%b", forward_a, exp_fa);
        end
      end
      tick;
    end
    checks++;
    if (nps != exp_st || nis != exp_st) begin
      failures++;
      $display("FAIL loaduse_stall_cycles actual=%0d/%0d expected=%0d", nps, nis, exp_st);
    end
    checks++;
    if (stall_count !== CNT_W'(exp_st)) begin
      failures++;
      $display("FAIL loaduse_stall_count actual=%0d expected=%0d", stall_count, exp_st);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL loaduse_rtype_reach_ex actual=0 expected=1");
    end
  endtask

  task automatic test_forwarding;
    for (int v = 0; v < 2; v++) begin
      int nps = 0;
      bit seen = 0;
      logic [4:0] r = (v == 0) ? 5'd3 : 5'd0;
      logic [1:0] exp_f = (v == 0 && FWD) ? 2'b10 : 2'b00;
      int exp_st = (v == 0 && !FWD) ? 2 : 0;
      do_reset;
      drive(K_R, 5'd1, 5'd2, r);
      tick;
      drive(K_R, r, r, 5'd4);
      for (int c = 0; c < 6; c++) begin
        settle;
        if (!pc_write) nps++;
        if (!seen && ex_regdst && ex_rs == r && ex_rt == r) begin
          seen = 1;
          checks++;
          if ({forward_a, forward_b} !== {exp_f, exp_f}) begin
            failures++;
            $display("FAIL fwd_select_v%0d actual=%b expected=%b", v, {forward_a, forward_b}, {exp_f, exp_f});
          end
        end
        tick;
      end
      checks++;
      if (!seen || nps != exp_st) begin
        failures++;
        $display("FAIL fwd_stalls_v%0d actual=%0d seen=%0d expected=%0d", v, nps, seen, exp_st);
      end
    end
  endtask

  task automatic test_branch;
    do_reset;
    drive(K_BEQ, 5'd1, 5'd2, 5'd0);
    tick;
    ex_zero = 1'b1;
    drive(K_LW, 5'd4, 5'd6, 5'd0);
    settle;
    checks++;
    if ({pcsrc, pc_write} !== 2'b01) begin
      failures++;
      $display("FAIL beq_in_ex actual=%b expected=01", {pcsrc, pc_write});
    end
    tick;
    ex_zero = 1'b0;
    drive(K_R, 5'd7, 5'd7, 5'd7);
    settle;
    checks++;
    if ({pcsrc, ifid_flush, pc_write} !== 3'b111) begin
      failures++;
      $display("FAIL beq_taken actual=%b expected=111", {pcsrc, ifid_flush, pc_write});
    end
    tick;
    settle;
    checks++;
    if ({ex_alusrc, ex_regdst, ex_aluop, mem_memread, mem_memwrite, pcsrc, ifid_flush} !== 8'd0) begin
      failures++;
      $display("FAIL beq_flushed actual=%b expected=00000000",
               {ex_alusrc, ex_regdst, ex_aluop, mem_memread, mem_memwrite, pcsrc, ifid_flush});
    end
    checks++;
    if (wb_regwrite !== 1'b0) begin
      failures++;
      $display("FAIL beq_wb_regwrite actual=%b expected=0", wb_regwrite);
    end
  endtask

  task automatic test_simultaneous;
    do_reset;
    drive(K_BEQ, 5'd1, 5'd2, 5'd0);
    tick;
    ex_zero = 1'b1;
    drive(K_LW, 5'd1, 5'd8, 5'd0);
    tick;
    ex_zero = 1'b0;
    drive(K_R, 5'd8, 5'd3, 5'd5);
    settle;
    checks++;
    if ({pcsrc, pc_write, ifid_write, ifid_flush} !== 4'b1111) begin
      failures++;
      $display("FAIL simul_flush_wins actual=%b expected=1111", {pcsrc, pc_write, ifid_write, ifid_flush});
    end
    tick;
    settle;
    checks++;
    if (stall_count !== '0) begin
      failures++;
      $display("FAIL simul_stall_count actual=%0d expected=0", stall_count);
    end
  endtask

  task automatic test_saturation;
    int nps = 0;
    bit hit = 0;
    do_reset;
    drive(K_LW, 5'd9, 5'd9, 5'd0);
    for (int c = 0; c < 2000 && !hit; c++) begin
      settle;
      if (stall_count === MAXC) hit = 1;
      else tick;
    end
    checks++;
    if (stall_count !== MAXC) begin
      failures++;
      $display("FAIL sat_reach_max actual=%0d expected=%0d", stall_count, MAXC);
    end
    for (int c = 0; c < 4; c++) begin
      tick;
      settle;
      if (!pc_write) nps++;
    end
    checks++;
    if (stall_count !== MAXC || nps == 0) begin
      failures++;
      $display("FAIL sat_hold actual=%0d stalls=%0d expected=%0d", stall_count, nps, MAXC);
    end
    for (int c = 0; c < 4 && pc_write; c++) begin
      tick;
      settle;
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({stall_count, pc_write, ifid_write} !== {{CNT_W{1'b0}}, 2'b11}) begin
      failures++;
      $display("FAIL sat_async_reset actual=%0d/%b expected=0/11", stall_count, {pc_write, ifid_write});
    end
    tick;
    reset = 1'b1;
  endtask

  task automatic test_random;
    stage_t me = '0, mm = '0, mw = '0;
    logic [CNT_W-1:0] cnt = '0;
    bit prev_stall = 0;
    do_reset;
    for (int n = 0; n < 400; n++) begin
      bit pc, hz, st;
      logic [1:0] fa, fb;
      stage_t ne;
      if (!prev_stall) begin
        int kind = $urandom_range(0, 5);
        drive(kind, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        if (kind == 5)
          {id_alusrc, id_memread, id_memwrite, id_memtoreg, id_regwrite, id_regdst, id_branch, id_aluop} = 9'($urandom);
      end
      ex_zero = 1'($urandom);
      settle;
      pc = mm.branch && mm.zero;
      hz = me.memread && me.dest != 0 && (me.dest == id_rs || me.dest == id_rt);
      if (!FWD)
        hz = hz || (me.regwrite && me.dest != 0 && (me.dest == id_rs || me.dest == id_rt))
                || (mm.regwrite && mm.dest != 0 && (mm.dest == id_rs || mm.dest == id_rt));
      st = hz && !pc;
      fa = 2'b00; fb = 2'b00;
      if (FWD) begin
        if (mm.regwrite && mm.dest != 0 && mm.dest == me.rs) fa = 2'b10;
        else if (mw.regwrite && mw.dest != 0 && mw.dest == me.rs) fa = 2'b01;
        if (mm.regwrite && mm.dest != 0 && mm.dest == me.rt) fb = 2'b10;
        else if (mw.regwrite && mw.dest != 0 && mw.dest == me.rt) fb = 2'b01;
      end
      checks++;
      if ({ex_alusrc, ex_regdst, ex_aluop, ex_rs, ex_rt} !== {me.alusrc, me.regdst, me.aluop, me.rs, me.rt}) begin
        failures++;
        $display("FAIL rand_ex cyc=%0d actual=%h expected=%h", n, {ex_alusrc, ex_regdst, ex_aluop, ex_rs, ex_rt},
                 {me.alusrc, me.regdst, me.aluop, me.rs, me.rt});
      end
      checks++;
      if ({mem_memread, mem_memwrite, pcsrc} !== {mm.memread, mm.memwrite, pc}) begin
        failures++;
        $display("FAIL rand_mem cyc=%0d actual=%b expected=%b", n, {mem_memread, mem_memwrite, pcsrc},
                 {mm.memread, mm.memwrite, pc});
      end
      checks++;
      if ({wb_memtoreg, wb_regwrite, wb_dest} !== {mw.memtoreg, mw.regwrite, mw.dest}) begin
        failures++;
        $display("FAIL rand_wb cyc=%0d actual=%b expected=%b", n, {wb_memtoreg, wb_regwrite, wb_dest},
                 {mw.memtoreg, mw.regwrite, mw.dest});
      end
      checks++;
      if ({pc_write, ifid_write, ifid_flush, forward_a, forward_b} !== {~st, ~st, pc, fa, fb}) begin
        failures++;
        $display("FAIL rand_hazard cyc=%0d actual=%b expected=%b", n,
                 {pc_write, ifid_write, ifid_flush, forward_a, forward_b}, {~st, ~st, pc, fa, fb});
      end
      checks++;
      if (stall_count !== cnt) begin
        failures++;
        $display("FAIL rand_count cyc=%0d actual=%0d expected=%0d", n, stall_count, cnt);
      end
      // advance the instruction-level model one clock
      ne = '0;
      if (!pc && !st) begin
        ne.alusrc = id_alusrc; ne.regdst = id_regdst; ne.aluop = id_aluop;
        ne.rs = id_rs; ne.rt = id_rt; ne.memread = id_memread; ne.memwrite = id_memwrite;
        ne.memtoreg = id_memtoreg; ne.regwrite = id_regwrite && !id_branch;
        ne.branch = id_branch; ne.dest = id_regdst ? id_rd : id_rt;
      end
      mw = mm;
      if (pc) mm = '0;
      else begin mm = me; mm.zero = ex_zero; end
      me = ne;
      if (st && cnt != MAXC) cnt = cnt + 1'b1;
      prev_stall = st;
      tick;
    end
  endtask

  initial begin
    drive(K_NOP, 0, 0, 0);
    ex_zero = 1'b0;
    test_reset;
    test_load_use;
    test_forwarding;
    test_branch;
    test_simultaneous;
    test_saturation;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
